// File: rtl/ksa_pkg.sv
// Shared constants and the S1 stage record for the arbitrated Kogge-Stone
// add/subtract unit.
package ksa_pkg;

   localparam int N_REQ = 4;
   localparam int DW    = 16;
   localparam int ID_W  = 2;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef struct packed {
      logic [DW-1:0]   a;
      logic [DW-1:0]   b;
      logic            sub;
      logic [ID_W-1:0] id;
   } s1_t;

endpackage

// File: rtl/ksa_top_16b.sv
// 16-bit Kogge-Stone parallel-prefix adder with carry-in and carry-out;
// purely combinational.
module ksa_top_16b (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [15:0] g0, p0, g1, p1, g2, p2, g3, p3, g4, p4;
   logic [16:0] carry;

   assign g0 = a & b;
   assign p0 = a ^ b;

   // Each level merges spans of width 1,2,4,8; low bits keep their group
   // terms, so propagate is padded with ones where no lower span exists.
   assign g1 = g0 | (p0 & {g0[14:0], 1'b0});
   assign p1 = p0 & {p0[14:0], 1'b1};
   assign g2 = g1 | (p1 & {g1[13:0], 2'b00});
   assign p2 = p1 & {p1[13:0], 2'b11};
   assign g3 = g2 | (p2 & {g2[11:0], 4'h0});
   assign p3 = p2 & {p2[11:0], 4'hF};
   assign g4 = g3 | (p3 & {g3[7:0], 8'h00});
   assign p4 = p3 & {p3[7:0], 8'hFF};

   // g4/p4[i] describe the whole span [i:0], so cin folds in with one AND-OR.
   assign carry = {g4 | (p4 & {16{cin}}), cin};
   assign sum   = p0 ^ carry[15:0];
   assign cout  = carry[16];

endmodule

// File: rtl/ksa_add_arbiter.sv
// Four-requester round-robin front end feeding a two-stage add/subtract
// pipeline built around one shared Kogge-Stone adder.
module ksa_add_arbiter #(
   parameter int N_REQ = ksa_pkg::N_REQ,
   parameter int DW    = ksa_pkg::DW
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [N_REQ-1:0]        i_req,
   input  logic [N_REQ-1:0]        i_sub,
   input  logic [N_REQ*DW-1:0]     i_a,
   input  logic [N_REQ*DW-1:0]     i_b,
   output logic [N_REQ-1:0]        o_gnt,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [DW-1:0]           o_sum,
   output logic                    o_carry,
   output logic                    o_ovf,
   output logic [ksa_pkg::ID_W-1:0] o_id,
   output logic                    o_busy
);

   localparam int ID_W = ksa_pkg::ID_W;

   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] idx;
   logic [ID_W-1:0] gnt_id;
   logic            gnt_any;
   logic            s1_rdy;
   logic            s2_rdy;

   logic            vld_p1;
   ksa_pkg::s1_t    st_p1;

   logic [DW-1:0]   b_eff;
   logic            cin;
   logic [DW-1:0]   sum_nx;
   logic            carry_nx;

   logic            vld_p2;
   logic [DW-1:0]   sum_p2;
   logic            carry_p2;
   logic            ovf_p2;
   logic [ID_W-1:0] id_p2;

   // Signed overflow: both addends share a sign the result does not.
   function automatic logic signed_ovf(input logic signed [DW-1:0] a,
                                       input logic signed [DW-1:0] b,
                                       input logic signed [DW-1:0] s);
      return (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
   endfunction

   assign s2_rdy = !vld_p2 || i_ready;
   assign s1_rdy = !vld_p1 || s2_rdy;

   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      idx     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = rr_ptr + ID_W'(i);
         if (!gnt_any && i_req[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = idx;
         end
      end
      // Gating with reset keeps the grant quiet while reset is held.
      gnt_any = gnt_any && s1_rdy && i_rst_n;
   end

   assign o_gnt = gnt_any ? (N_REQ'(1) << gnt_id) : '0;

   // ---- stage p1: capture the granted requester's operands ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p1 <= 1'b0;
         rr_ptr <= '0;
         st_p1  <= '0;
      end else begin
         if (s1_rdy)
            vld_p1 <= gnt_any;
         if (gnt_any) begin
            st_p1.a   <= i_a[gnt_id*DW +: DW];
            st_p1.b   <= i_b[gnt_id*DW +: DW];
            st_p1.sub <= i_sub[gnt_id];
            st_p1.id  <= gnt_id;
            rr_ptr    <= gnt_id + 1'b1;
         end
      end
   end

   assign b_eff = (st_p1.sub == ksa_pkg::OP_SUB) ? ~st_p1.b : st_p1.b;
   assign cin   = (st_p1.sub != ksa_pkg::OP_ADD);

   ksa_top_16b u_ksa (
      .a    (st_p1.a),
      .b    (b_eff),
      .cin  (cin),
      .sum  (sum_nx),
      .cout (carry_nx)
   );

   // ---- stage p2: result registers, held while downstream stalls ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p2   <= 1'b0;
         sum_p2   <= '0;
         carry_p2 <= 1'b0;
         ovf_p2   <= 1'b0;
         id_p2    <= '0;
      end else if (s2_rdy) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            sum_p2   <= sum_nx;
            carry_p2 <= carry_nx;
            ovf_p2   <= signed_ovf(st_p1.a, b_eff, sum_nx);
            id_p2    <= st_p1.id;
         end
      end
   end

   assign o_valid = vld_p2;
   assign o_sum   = sum_p2;
   assign o_carry = carry_p2;
   assign o_ovf   = ovf_p2;
   assign o_id    = id_p2;
   assign o_busy  = vld_p1 || vld_p2;

endmodule

// File: tb/tb_ksa_add_arbiter.sv
// Directed bench for ksa_add_arbiter: single operations, round-robin order,
// backpressure delivery and mid-stream reset.
module tb_ksa_add_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  sub;
   logic [63:0] a;
   logic [63:0] b;
   logic        ready;
   logic [3:0]  gnt;
   logic        valid;
   logic [15:0] sum;
   logic        carry;
   logic        ovf;
   logic [1:0]  id;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [15:0] exp_sum [4] = '{16'h1100, 16'h2201, 16'h3302, 16'h4403};

   ksa_add_arbiter dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_req   (req),
      .i_sub   (sub),
      .i_a     (a),
      .i_b     (b),
      .o_gnt   (gnt),
      .o_valid (valid),
      .i_ready (ready),
      .o_sum   (sum),
      .o_carry (carry),
      .o_ovf   (ovf),
      .o_id    (id),
      .o_busy  (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Requester k: a = 0x1000*(k+1)+k, b = 0x0100*(k+1), add.
   task automatic load_all();
      sub = '0;
      for (int k = 0; k < 4; k++) begin
         a[k*16 +: 16] = 16'(16'h1000 * (k + 1) + k);
         b[k*16 +: 16] = 16'(16'h0100 * (k + 1));
      end
   endtask

   // Issues one op for requester k; returns at cycle t+2 (+1) with the
   // grant seen at t and o_valid seen at t+1.
   task automatic run_single(input int k, input logic s, input logic [15:0] av,
                             input logic [15:0] bv, output logic [3:0] g_t,
                             output logic v_t1);
      @(negedge clk);
      req   = 4'(1 << k);
      sub   = '0;
      sub[k] = s;
      a     = '0;
      b     = '0;
      a[k*16 +: 16] = av;
      b[k*16 +: 16] = bv;
      ready = 1'b1;
      #1 g_t = gnt;
      @(negedge clk);
      req = '0;
      #1 v_t1 = valid;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 4'hF;
      sub   = '0;
      a     = '0;
      b     = '0;
      ready = 1'b1;
      #2;
      total++;
      if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
      total++;
      if (valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_valid_busy got=%b%b want=00", valid, busy); end
      total++;
      if ({sum, carry, ovf, id} !== 20'h0) begin bad++; $display("FAIL reset_data got=%h want=0", {sum, carry, ovf, id}); end
      @(negedge clk);
      rst_n = 1'b1;
      req   = '0;
   endtask

   task automatic test_add();
      logic [3:0] g;
      logic v1;
      run_single(0, 1'b0, 16'h1234, 16'h0FFF, g, v1);
      total++;
      if (g !== 4'b0001) begin bad++; $display("FAIL add_gnt got=%b want=0001", g); end
      total++;
      if (v1 !== 1'b0) begin bad++; $display("FAIL add_latency_t1 got=%b want=0", v1); end
      total++;
      if ({valid, sum, carry, ovf, id} !== {1'b1, 16'h2233, 1'b0, 1'b0, 2'd0}) begin
         bad++; $display("FAIL add_result got=%b/%h/%b/%b/%0d want=1/2233/0/0/0", valid, sum, carry, ovf, id);
      end
      @(negedge clk);
      #1;
      total++;
      if (valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL add_drain got=%b%b want=00", valid, busy); end
   endtask

   task automatic test_sub();
      logic [3:0] g;
      logic v1;
      run_single(2, 1'b1, 16'h0003, 16'h0005, g, v1);
      total++;
      if (g !== 4'b0100) begin bad++; $display("FAIL sub_gnt got=%b want=0100", g); end
      total++;
      if ({valid, sum, carry, ovf, id} !== {1'b1, 16'hFFFE, 1'b0, 1'b0, 2'd2}) begin
         bad++; $display("FAIL sub_borrow got=%b/%h/%b/%b/%0d want=1/fffe/0/0/2", valid, sum, carry, ovf, id);
      end
      run_single(3, 1'b1, 16'h0005, 16'h0003, g, v1);
      total++;
      if ({valid, sum, carry, ovf, id} !== {1'b1, 16'h0002, 1'b1, 1'b0, 2'd3}) begin
         bad++; $display("FAIL sub_noborrow got=%b/%h/%b/%b/%0d want=1/0002/1/0/3", valid, sum, carry, ovf, id);
      end
   endtask

   task automatic test_ovf();
      logic [3:0] g;
      logic v1;
      run_single(1, 1'b0, 16'h7FFF, 16'h0001, g, v1);
      total++;
      if ({valid, sum, carry, ovf, id} !== {1'b1, 16'h8000, 1'b0, 1'b1, 2'd1}) begin
         bad++; $display("FAIL add_ovf got=%b/%h/%b/%b/%0d want=1/8000/0/1/1", valid, sum, carry, ovf, id);
      end
      run_single(0, 1'b1, 16'h8000, 16'h0001, g, v1);
      total++;
      if ({valid, sum, carry, ovf} !== {1'b1, 16'h7FFF, 1'b1, 1'b1}) begin
         bad++; $display("FAIL sub_ovf got=%b/%h/%b/%b want=1/7fff/1/1", valid, sum, carry, ovf);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      load_all();
      req   = 4'hF;
      ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         total++;
         if (gnt !== 4'(1 << (c % 4))) begin bad++; $display("FAIL rr_gnt c=%0d got=%b want=%b", c, gnt, 4'(1 << (c % 4))); end
         total++;
         if (c < 2) begin
            if (valid !== 1'b0) begin bad++; $display("FAIL rr_early_valid c=%0d got=%b want=0", c, valid); end
         end else if ({valid, id, sum} !== {1'b1, 2'((c - 2) % 4), exp_sum[(c - 2) % 4]}) begin
            bad++; $display("FAIL rr_out c=%0d got=%b/%0d/%h want=1/%0d/%h", c, valid, id, sum, (c - 2) % 4, exp_sum[(c - 2) % 4]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] pending;
      int bp_grants;
      int n_out;
      do_reset();
      load_all();
      pending   = 4'hF;
      bp_grants = 0;
      n_out     = 0;
      for (int c = 0; c < 14; c++) begin
         if (c > 0) @(negedge clk);
         req   = pending;
         ready = (c >= 5);
         #1;
         if (gnt != 4'b0000) begin
            if (c < 5) bp_grants++;
            pending = pending & ~gnt;
         end
         if (c >= 2 && c < 5) begin
            total++;
            if ({valid, id, sum} !== {1'b1, 2'd0, 16'h1100}) begin
               bad++; $display("FAIL bp_frozen c=%0d got=%b/%0d/%h want=1/0/1100", c, valid, id, sum);
            end
         end
         if (valid && ready) begin
            total++;
            if (n_out >= 4) begin
               bad++; $display("FAIL bp_extra c=%0d got=id%0d want=no result", c, id);
            end else if (id !== 2'(n_out) || sum !== exp_sum[n_out]) begin
               bad++; $display("FAIL bp_order n=%0d got=%0d/%h want=%0d/%h", n_out, id, sum, n_out, exp_sum[n_out]);
            end
            n_out++;
         end
      end
      total++;
      if (bp_grants != 2) begin bad++; $display("FAIL bp_grants got=%0d want=2", bp_grants); end
      total++;
      if (n_out != 4) begin bad++; $display("FAIL bp_count got=%0d want=4", n_out); end
      total++;
      if (busy !== 1'b0 || pending !== 4'h0) begin bad++; $display("FAIL bp_idle got=%b/%b want=0/0000", busy, pending); end
   endtask

   task automatic test_reset_mid();
      logic stray;
      do_reset();
      load_all();
      req   = 4'hF;
      ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      total++;
      if (valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%b%b want=11", valid, busy); end
      rst_n = 1'b0;
      #1;
      total++;
      if ({valid, busy, gnt, sum} !== 22'h0) begin
         bad++; $display("FAIL rst_mid_clear got=%b/%b/%b/%h want=0/0/0000/0000", valid, busy, gnt, sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      req   = '0;
      ready = 1'b1;
      stray = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1 stray = stray | valid | busy;
         @(negedge clk);
      end
      total++;
      if (stray !== 1'b0) begin bad++; $display("FAIL rst_mid_stray got=%b want=0", stray); end
      req = 4'hF;
      #1;
      total++;
      if (gnt !== 4'b0001) begin bad++; $display("FAIL rst_mid_first_gnt got=%b want=0001", gnt); end
      @(negedge clk);
      req = '0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_ovf();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
